// File: rtl/led_scanner_pkg.sv
// +----------------------------------------------------------------------------+
// | led_scanner_pkg : shared types and constants for the LED scanner block     |
// | Revision        : 1.0 - initial release                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package led_scanner_pkg;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } state_e;

  localparam int LED_N = 8;
  localparam int LVL_W = 4;
  localparam logic [LVL_W-1:0] LVL_MAX = 4'd15;

  function automatic logic [LVL_W-1:0] sat_sub(input logic [LVL_W-1:0] a,
                                               input logic [LVL_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm.sv
// +----------------------------------------------------------------------------+
// | led_pwm  : free-running 4-bit PWM with eight registered level comparators  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module led_pwm
  import led_scanner_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [LED_N*LVL_W-1:0] lvl_i,
  output logic [LED_N-1:0]       led_o
);

  logic [LVL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LED_N-1:0] led_q, led_d;

  // Strict compare: level 15 is lit for 15 of 16 phases, level 0 never.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    led_d     = '0;
    for (int i = 0; i < LED_N; i++) begin
      led_d[i] = lvl_i[i*LVL_W +: LVL_W] > pwm_cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

`default_nettype wire

// File: rtl/led_scanner.sv
// +----------------------------------------------------------------------------+
// | led_scanner : bouncing/wrapping scanner dot on eight LEDs                  |
// |               LED_SCANNER_TRAIL_EN adds a decaying PWM brightness trail    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int STEP_DIV = 6000000,
  parameter int DECAY    = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             mode_i,
  output logic [LED_N-1:0] led_o,
  output logic [2:0]       pos_o
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  if (STEP_DIV < 2 || DECAY < 0 || DECAY > 15) begin : g_param_check
    $error("led_scanner: STEP_DIV must be >= 2 and DECAY within 0..15");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step;
  state_e           state_q, state_d;
  logic [2:0]       pos_q, pos_d;

  always_comb begin
    step  = en_i && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = step ? '0 : cnt_q + 1'b1;
    end
  end

  // Wrap mode always leaves the FSM heading right, whatever it was doing.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    if (step) begin
      if (mode_i) begin
        state_d = RIGHT;
        pos_d   = pos_q + 3'd1;
      end else if (state_q == RIGHT) begin
        if (pos_q == 3'd7) begin
          state_d = LEFT;
          pos_d   = 3'd6;
        end else begin
          pos_d = pos_q + 3'd1;
        end
      end else begin
        if (pos_q == 3'd0) begin
          state_d = RIGHT;
          pos_d   = 3'd1;
        end else begin
          pos_d = pos_q - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      state_q <= RIGHT;
      pos_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  assign pos_o = pos_q;

`ifdef LED_SCANNER_TRAIL_EN
  localparam logic [LVL_W-1:0] DECAY_L = LVL_W'(DECAY);
  localparam logic [LED_N*LVL_W-1:0] LVL_RST = {{((LED_N-1)*LVL_W){1'b0}}, LVL_MAX};

  logic [LED_N*LVL_W-1:0] lvl_q, lvl_d;

  // The newly active LED is forced to full brightness after the decay.
  always_comb begin
    lvl_d = lvl_q;
    if (step) begin
      for (int i = 0; i < LED_N; i++) begin
        lvl_d[i*LVL_W +: LVL_W] = (3'(i) == pos_d) ? LVL_MAX
                                                   : sat_sub(lvl_q[i*LVL_W +: LVL_W], DECAY_L);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lvl_q <= LVL_RST;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  led_pwm u_led_pwm (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .lvl_i   (lvl_q),
    .led_o   (led_o)
  );
`else
  logic [LED_N-1:0] led_q, led_d;

  always_comb begin
    led_d = LED_N'(1) << pos_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_o = led_q;
`endif

endmodule

`default_nettype wire

// File: doc/led_scanner.md
# led_scanner

Drives the eight board LEDs with a bouncing or wrapping "scanner" dot that leaves a fading PWM trail. It replaces the raw counter-bit LED tap in the top level. It sits directly downstream of `clks` on the 96 MHz `clk_96` domain and owns `led_o`.

## Interface
- `STEP_DIV`, default 6000000: clock cycles per scanner step (62.5 ms at 96 MHz); minimum 2.
- `DECAY`, default 4: brightness subtracted from every non-active LED per step; range 0..15.
- `clk_i`  in  1  96 MHz system clock (`clk_96`).
- `rst_n_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en_i`  in  1  run enable; low freezes the prescaler, position and brightness levels.
- `mode_i`  in  1  0 = bounce, 1 = wrap; sampled only on a step.
- `led_o`  out  8  LED drive, registered.
- `pos_o`  out  3  current active LED index, registered.

## Operation
- **Prescaler:** `cnt` runs 0..STEP_DIV-1 while `en_i`=1.
  - `step` is high in the cycle where `cnt`==STEP_DIV-1 and `en_i`=1.
  - `cnt` then wraps to 0.
- **FSM:** states RIGHT (pos increments) and LEFT (pos decrements). Transitions occur only on `step`:
  - Bounce, RIGHT: pos<7 → pos+1. pos==7 → LEFT, pos 6.
  - Bounce, LEFT: pos>0 → pos-1. pos==0 → RIGHT, pos 1.
  - Wrap (any state): → RIGHT, pos=(pos+1) mod 8, so 7 → 0.
  - A LEFT→wrap switch increments from the current pos.
- **Brightness:** eight 4-bit levels, 0..15. On `step`:
  - Every level is decremented by DECAY, saturating at 0.
  - The new pos level is then forced to 15. The force overrides the decrement.
- **PWM:** 4-bit `pwm_cnt` increments every clock, independent of `en_i`, and wraps 15→0.
  - `led_o[i]` is the registered value of `level[i] > pwm_cnt`.
  - Level 15 gives a 15/16 duty cycle. Level 0 is always off.

## Timing
- **Reset values:** `cnt`=0, `pwm_cnt`=0, state RIGHT, pos 0, `pos_o`=0, `led_o`=8'h00. `level[0]`=15 and all other levels are 0.
- On the first clock after reset release, `led_o` becomes 8'h01, because 15>0.
- **Step latency:**
  - pos, state and levels update on the clock edge that ends the `step` cycle.
  - `pos_o` updates on that same edge.
  - `led_o` reflects the new levels one clock later.
- **`en_i` deasserted mid-count:** `cnt` holds its value, and counting resumes from that value when `en_i` returns high. `led_o` keeps being driven from the frozen levels, so the LEDs stay lit and dimmed.
- **`mode_i` change between steps:** no effect until the next `step`.
- **Reset asserted mid-operation:** all registers return to their reset values immediately, without waiting for a clock.
- **Prescaler width:** `cnt` width is $clog2(STEP_DIV). The terminal compare uses STEP_DIV-1 at that width. There is no overflow path.

## Configuration
- Macro `LED_SCANNER_TRAIL_EN`.
- **Defined:** brightness levels and PWM are implemented exactly as described above.
- **Undefined:**
  - No levels, no PWM and no DECAY logic.
  - `led_o` is the registered one-hot of pos at full brightness.
  - `led_o` follows `pos_o` with one clock of lag and resets to 8'h00. It becomes 8'h01 one clock after reset release.
  - The FSM, prescaler and `pos_o` behave identically in both builds.

## Structure
- **Shared package `led_scanner_pkg`:**
  - state enum `{RIGHT, LEFT}`.
  - `LED_N`=8, `LVL_W`=4, `LVL_MAX`=15.
- **Sub-module `led_pwm`:**
  - Contains the free-running `pwm_cnt` and the eight registered comparators.
  - Input is the packed level vector; output is `led_o`.
  - Instantiated only under `LED_SCANNER_TRAIL_EN`.
- The top holds the prescaler, FSM, pos and the level update.

## Test plan
All scenarios use STEP_DIV=4 and DECAY=4.
- **Reset:**
  - While reset is held: `led_o`=8'h00 and `pos_o`=0, including when reset asserts mid-run.
  - After release: `led_o`=8'h01 after one clock.
  - The first step arrives on cycle 4.
- **Bounce:** `mode_i`=0, run 16 steps → `pos_o` sequence 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2.
- **Wrap:** `mode_i`=1 from pos 6, state RIGHT → `pos_o` 7,0,1. Then switch to `mode_i`=0 at pos 1 → bounce continues 2,3,…
- **Decay (TRAIL_EN defined):**
  - After the step to pos 1: `level[0]`=11 and `level[1]`=15.
  - After the next step: 7, 11, 15 for LEDs 0..2.
  - Over 16 clocks, `led_o[0]` is high for exactly 7 cycles.
- **Enable freeze:**
  - Drop `en_i` at `cnt`=2 for 50 clocks → `pos_o` and levels unchanged.
  - After re-enable, the next step occurs 2 clocks later.
- **Trail disabled (macro undefined):** bounce run → `led_o` equals 1<<`pos_o` delayed by one clock, and no other bits are ever set.
